// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive lamp legality, phase order and duration checker
// Decodes six lamp outputs into a phase, flags illegal lamps/sequences/durations, counts cycles.
module traffic_light_monitor #(
   parameter int TIME_W = 6,
   parameter int CNT_W  = 8,
   parameter int DUR_W  = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              HG,
   input  logic              HY,
   input  logic              HR,
   input  logic              FG,
   input  logic              FY,
   input  logic              FR,
   input  logic [TIME_W-1:0] ShortTime_i,
   input  logic [TIME_W-1:0] LongTime_i,
   input  logic              clr_i,
   output logic [1:0]        phase_o,
   output logic              phase_valid_o,
   output logic              err_lamp_o,
   output logic              err_seq_o,
   output logic              err_time_o,
   output logic [CNT_W-1:0]  cycle_count_o
);

   typedef enum logic {SYNC, TRACK} state_t;

   state_t            state, state_nxt;
   logic [5:0]        lamps;
   logic              legal;
   logic [1:0]        dec_phase, phase_nxt;
   logic [TIME_W-1:0] dec_exp, exp_dur, exp_nxt;
   logic [DUR_W-1:0]  dur, dur_nxt, exp_ext;
   logic              checked, checked_nxt, valid_nxt;
   logic              ev_lamp, ev_seq, ev_time, wrap;
   logic              lamp_nxt, seq_nxt, time_nxt;
   logic [CNT_W-1:0]  cnt_nxt;

   assign lamps   = {HG, HY, HR, FG, FY, FR};
   assign dec_exp = dec_phase[0] ? ShortTime_i : LongTime_i;
   assign exp_ext = DUR_W'(exp_dur);

   always_comb begin
      legal     = 1'b1;
      dec_phase = 2'd0;
      case (lamps)
         6'b100001: dec_phase = 2'd0;
         6'b010001: dec_phase = 2'd1;
         6'b001100: dec_phase = 2'd2;
         6'b001010: dec_phase = 2'd3;
         default:   legal     = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt   = state;
      phase_nxt   = phase_o;
      valid_nxt   = phase_valid_o;
      dur_nxt     = dur;
      exp_nxt     = exp_dur;
      checked_nxt = checked;
      ev_lamp     = 1'b0;
      ev_seq      = 1'b0;
      ev_time     = 1'b0;
      wrap        = 1'b0;
      if (!legal) begin
         ev_lamp   = 1'b1;
         state_nxt = SYNC;
         valid_nxt = 1'b0;
      end else if (state == SYNC) begin
         // Start of this phase was not observed, so its length cannot be judged.
         state_nxt   = TRACK;
         valid_nxt   = 1'b1;
         phase_nxt   = dec_phase;
         dur_nxt     = DUR_W'(1);
         checked_nxt = 1'b0;
         exp_nxt     = dec_exp;
      end else if (dec_phase == phase_o) begin
         valid_nxt = 1'b1;
         if (checked && exp_dur != '0 && dur == exp_ext)
            ev_time = 1'b1;
         if (dur != '1)
            dur_nxt = dur + DUR_W'(1);
      end else if (dec_phase == phase_o + 2'd1) begin
         valid_nxt = 1'b1;
         if (checked && exp_dur != '0 && dur != exp_ext)
            ev_time = 1'b1;
         wrap        = (phase_o == 2'd3);
         phase_nxt   = dec_phase;
         dur_nxt     = DUR_W'(1);
         checked_nxt = 1'b1;
         exp_nxt     = dec_exp;
      end else begin
         valid_nxt   = 1'b1;
         ev_seq      = 1'b1;
         phase_nxt   = dec_phase;
         dur_nxt     = DUR_W'(1);
         checked_nxt = 1'b0;
         exp_nxt     = dec_exp;
      end
      // A clear on the same edge as an error event still leaves the flag set.
      lamp_nxt = (err_lamp_o & ~clr_i) | ev_lamp;
      seq_nxt  = (err_seq_o  & ~clr_i) | ev_seq;
      time_nxt = (err_time_o & ~clr_i) | ev_time;
      if (clr_i)
         cnt_nxt = '0;
      else if (wrap)
         cnt_nxt = cycle_count_o + CNT_W'(1);
      else
         cnt_nxt = cycle_count_o;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= SYNC;
         phase_o       <= 2'd0;
         phase_valid_o <= 1'b0;
         err_lamp_o    <= 1'b0;
         err_seq_o     <= 1'b0;
         err_time_o    <= 1'b0;
         cycle_count_o <= '0;
         dur           <= '0;
         exp_dur       <= '0;
         checked       <= 1'b0;
      end else begin
         state         <= state_nxt;
         phase_o       <= phase_nxt;
         phase_valid_o <= valid_nxt;
         err_lamp_o    <= lamp_nxt;
         err_seq_o     <= seq_nxt;
         err_time_o    <= time_nxt;
         cycle_count_o <= cnt_nxt;
         dur           <= dur_nxt;
         exp_dur       <= exp_nxt;
         checked       <= checked_nxt;
      end
   end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed scoreboard bench for traffic_light_monitor
module tb_traffic_light_monitor;

   localparam logic [5:0] P0 = 6'b100001;
   localparam logic [5:0] P1 = 6'b010001;
   localparam logic [5:0] P2 = 6'b001100;
   localparam logic [5:0] P3 = 6'b001010;

   typedef struct packed {
      logic [1:0] phase;
      logic       valid;
      logic       lamp;
      logic       seq;
      logic       tim;
      logic [7:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] lamps = P0;
   logic [5:0] short_t = 6'd3;
   logic [5:0] long_t = 6'd5;
   logic       clr = 1'b0;
   logic [1:0] phase;
   logic       phase_valid, err_lamp, err_seq, err_time;
   logic [7:0] cycle_count;

   int tests = 0;
   int failed = 0;
   exp_t sb[$];

   // Reference model state
   logic [1:0] m_phase;
   logic       m_valid, m_lamp, m_seq, m_time, m_track, m_chk;
   logic [7:0] m_cnt;
   int         m_dur, m_exp;

   traffic_light_monitor dut (
      .clk(clk), .rst_n(rst_n),
      .HG(lamps[5]), .HY(lamps[4]), .HR(lamps[3]),
      .FG(lamps[2]), .FY(lamps[1]), .FR(lamps[0]),
      .ShortTime_i(short_t), .LongTime_i(long_t), .clr_i(clr),
      .phase_o(phase), .phase_valid_o(phase_valid),
      .err_lamp_o(err_lamp), .err_seq_o(err_seq), .err_time_o(err_time),
      .cycle_count_o(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_valid = 0; m_lamp = 0; m_seq = 0; m_time = 0;
      m_track = 0; m_chk = 0; m_cnt = 0; m_dur = 0; m_exp = 0;
   endtask

   function automatic int pat2ph(input logic [5:0] l);
      case (l)
         P0: return 0;
         P1: return 1;
         P2: return 2;
         P3: return 3;
         default: return -1;
      endcase
   endfunction

   function automatic int exp_of(input int ph);
      return (ph % 2 == 1) ? int'(short_t) : int'(long_t);
   endfunction

   task automatic model_step(input logic [5:0] l, input logic c);
      int  ph;
      bit  el, es, et, inc;
      ph = pat2ph(l);
      el = 0; es = 0; et = 0; inc = 0;
      if (ph < 0) begin
         el = 1; m_track = 0; m_valid = 0;
      end else if (!m_track) begin
         m_track = 1; m_valid = 1; m_phase = 2'(ph); m_dur = 1; m_chk = 0; m_exp = exp_of(ph);
      end else if (ph == int'(m_phase)) begin
         if (m_chk && m_exp != 0 && m_dur == m_exp) et = 1;
         if (m_dur < 127) m_dur++;
      end else if (ph == (int'(m_phase) + 1) % 4) begin
         if (m_chk && m_exp != 0 && m_dur != m_exp) et = 1;
         inc = (m_phase == 2'd3);
         m_phase = 2'(ph); m_dur = 1; m_chk = 1; m_exp = exp_of(ph);
      end else begin
         es = 1; m_phase = 2'(ph); m_dur = 1; m_chk = 0; m_exp = exp_of(ph);
      end
      if (c) begin
         m_lamp = 0; m_seq = 0; m_time = 0; m_cnt = 0;
      end else if (inc) begin
         m_cnt = m_cnt + 8'd1;
      end
      m_lamp |= el; m_seq |= es; m_time |= et;
   endtask

   task automatic cyc(input logic [5:0] l, input logic c);
      exp_t e;
      @(negedge clk);
      lamps = l;
      clr = c;
      model_step(l, c);
      e = '{phase: m_phase, valid: m_valid, lamp: m_lamp, seq: m_seq, tim: m_time, cnt: m_cnt};
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("phase", 32'(phase), 32'(e.phase));
      check("phase_valid", 32'(phase_valid), 32'(e.valid));
      check("err_lamp", 32'(err_lamp), 32'(e.lamp));
      check("err_seq", 32'(err_seq), 32'(e.seq));
      check("err_time", 32'(err_time), 32'(e.tim));
      check("cycle_count", 32'(cycle_count), 32'(e.cnt));
      clr = 1'b0;
   endtask

   task automatic hold(input logic [5:0] l, input int n);
      for (int i = 0; i < n; i++) cyc(l, 1'b0);
   endtask

   task automatic full_cycle();
      hold(P1, 3); hold(P2, 5); hold(P3, 3); hold(P0, 5);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_phase"}, 32'(phase), 0);
      check({tag, "_valid"}, 32'(phase_valid), 0);
      check({tag, "_errs"}, 32'({err_lamp, err_seq, err_time}), 0);
      check({tag, "_cnt"}, 32'(cycle_count), 0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_reset_vals("reset");
      @(negedge clk) rst_n = 1'b1;

      // Correct sequence, three full cycles
      hold(P0, 5);
      check("first_valid", 32'(phase_valid), 1);
      full_cycle(); check("cnt_1", 32'(cycle_count), 1);
      full_cycle(); check("cnt_2", 32'(cycle_count), 2);
      full_cycle(); check("cnt_3", 32'(cycle_count), 3);
      check("clean_errs", 32'({err_lamp, err_seq, err_time}), 0);

      // Illegal lamp pattern, then resync with an unchecked phase
      hold(P1, 1);
      cyc(6'b110001, 1'b0);
      check("lamp_err", 32'(err_lamp), 1);
      check("lamp_valid", 32'(phase_valid), 0);
      hold(P1, 2); hold(P2, 5); hold(P3, 3); hold(P0, 5);
      check("resync_time", 32'(err_time), 0);

      // Clear
      cyc(P1, 1'b1);
      check("clr_errs", 32'({err_lamp, err_seq, err_time}), 0);
      check("clr_cnt", 32'(cycle_count), 0);
      hold(P1, 2); hold(P2, 5); hold(P3, 3); hold(P0, 2);

      // Jump 0 -> 2 and resume checked 2 -> 3
      hold(P2, 5);
      check("seq_err", 32'(err_seq), 1);
      check("seq_time", 32'(err_time), 0);
      hold(P3, 3); hold(P0, 5);
      check("seq_follow_time", 32'(err_time), 0);

      // Overrun: phase 1 held 4 clocks
      cyc(P1, 1'b1);
      hold(P1, 2);
      check("overrun_pre", 32'(err_time), 0);
      hold(P1, 1);
      check("overrun", 32'(err_time), 1);
      hold(P2, 5); hold(P3, 3); hold(P0, 5);

      // Underrun: phase 1 held 2 clocks
      cyc(P1, 1'b1);
      hold(P1, 1);
      check("underrun_pre", 32'(err_time), 0);
      hold(P2, 1);
      check("underrun", 32'(err_time), 1);

      // Clear coinciding with an overrun
      cyc(P2, 1'b1); hold(P2, 3);
      check("pre_clr_overrun", 32'(err_time), 0);
      cyc(P2, 1'b1);
      check("clr_vs_overrun", 32'(err_time), 1);

      // Asynchronous reset mid-phase 2
      cyc(P3, 1'b1); hold(P3, 2); hold(P0, 5); hold(P1, 3); hold(P2, 2);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("async_rst");
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_reset_vals("rst_hold");
      @(negedge clk) rst_n = 1'b1;
      hold(P2, 3); hold(P3, 3); hold(P0, 5);
      check("post_rst_time", 32'(err_time), 0);
      check("post_rst_cnt", 32'(cycle_count), 1);

      check("sb_empty", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker that observes the six lamp outputs of the traffic light controller (highway HG/HY/HR, farm road FG/FY/FR).
- Decodes the lamps into a phase, checks lamp legality, phase ordering and phase durations against the programmed ShortTime_i/LongTime_i, and counts completed light cycles.
- Sits beside the controller in simulation benches and on-chip as a safety watchdog; never drives the lamps.

Parameters:
- TIME_W, 6, width of ShortTime_i/LongTime_i.
- CNT_W, 8, width of cycle_count_o.
- DUR_W, 7, width of the internal phase-duration counter; saturates at 2^DUR_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- HG, HY, HR  input  1 each  highway green/yellow/red lamps.
- FG, FY, FR  input  1 each  farm green/yellow/red lamps.
- ShortTime_i  input  TIME_W  expected yellow-phase duration in clocks.
- LongTime_i  input  TIME_W  expected green-phase duration in clocks.
- clr_i  input  1  synchronous clear of sticky error flags and cycle_count_o.
- phase_o  output  2  decoded phase: 0=HG/FR, 1=HY/FR, 2=HR/FG, 3=HR/FY.
- phase_valid_o  output  1  high while in TRACK state with a legal lamp pattern.
- err_lamp_o  output  1  sticky: illegal lamp combination seen.
- err_seq_o  output  1  sticky: illegal phase transition seen.
- err_time_o  output  1  sticky: phase duration mismatch.
- cycle_count_o  output  CNT_W  completed phase 3->0 transitions; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, async): state SYNC, phase_o=0, phase_valid_o=0, all err flags=0, cycle_count_o=0, duration counter=0. All outputs are registered.
- Decode (combinational on inputs): legal patterns are exactly {HG,HY,HR,FG,FY,FR} = 100001, 010001, 001100, 001010. Any other pattern is illegal.
- State machine: SYNC, TRACK.
- SYNC:
  - Legal pattern -> TRACK; phase_o loads the decoded phase; duration counter=1.
  - The first phase after entering TRACK is marked unchecked; the monitor has no knowledge of its start.
- TRACK, same phase as the previous cycle:
  - Duration counter increments, saturating.
  - If the phase is checked, expected E is nonzero and counter == E before the increment, set err_time_o (overrun).
- TRACK, successor phase (p -> (p+1) mod 4):
  - If the departing phase is checked, E != 0 and counter != E, set err_time_o (underrun).
  - Counter=1; the new phase is checked.
  - If the transition is 3->0, cycle_count_o increments.
- TRACK, non-successor legal phase:
  - Set err_seq_o; no duration check.
  - Load the new phase unchecked; counter=1; stay in TRACK.
- Illegal pattern in any state:
  - Set err_lamp_o, go to SYNC, phase_valid_o=0.
  - Set phase_valid_o=1 on the edge that enters TRACK.
- Expected duration E:
  - Phases 0 and 2 use LongTime_i; phases 1 and 3 use ShortTime_i.
  - Latch E at phase entry; changes to the inputs mid-phase take effect at the next phase.
  - E == 0 disables the duration check for that phase.
- Flag timing:
  - A flag is visible after the rising edge that samples the offending input.
  - Flags are sticky until clr_i or reset.
- clr_i:
  - Clears the three error flags and cycle_count_o on that edge. It does not change the state, phase or counter.
  - If an error event occurs on the same edge, the error wins and the flag is set.
- Reset mid-phase: immediate return to reset values; the next legal pattern starts an unchecked phase.

Test Plan:
- Short=3, Long=5, correct controller sequence for 3 full cycles (16 clocks/cycle) -> err_* stay 0; cycle_count_o steps 0->1->2->3 at each 3->0 transition; phase_valid_o=1 from the first legal sample.
- Drive HG and HY high together with FR for one clock mid-sequence -> err_lamp_o=1 after that edge, phase_valid_o=0; next legal pattern -> TRACK, and its phase produces no err_time_o.
- Jump from phase 0 directly to phase 2 -> err_seq_o=1, err_time_o stays 0; the following 2->3 transition is checked normally.
- Hold phase 1 (HY/FR) for 4 clocks with Short=3 -> err_time_o=1 on the 4th sample. Separately, hold phase 1 for 2 clocks -> err_time_o=1 at the transition to phase 2.
- Pulse clr_i after errors -> all flags=0 and cycle_count_o=0 next edge. Assert clr_i on the same edge as an overrun -> err_time_o=1.
- Assert rst_n low asynchronously mid-phase 2 -> outputs at reset values immediately. Release reset mid-phase -> first phase unchecked, no false err_time_o.
